// File: rtl/uart_pkg.sv
// Shared definitions for the Avalon UART transmit responder:
// shift FSM state encodings, STATUS word bit positions and the default baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // STATUS word layout
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_EMPTY_BIT = 2;
    localparam int unsigned STAT_FREE_LSB  = 8;

    // 50 MHz clock, 115200 baud
    localparam int unsigned DEFAULT_BAUD_DIV = 434;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO, 2**AW entries, first-word fall-through read port.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    logic [7:0]    mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == DEPTH);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/av_uart_tx_responder.sv
// Avalon-MM UART transmitter: DATA register at BASE_ADDR queues bytes into a FIFO,
// STATUS at BASE_ADDR+1 reports busy/full/empty/free entries, bytes leave on txd.
// Build option: define AV_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame);
// otherwise frames are 8N1.
module av_uart_tx_responder
    import uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0100,
    parameter int unsigned BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] av_address,
    input  logic [15:0] av_writedata,
    input  logic        av_write,
    input  logic        av_read,
    output logic [15:0] av_readdata,
    output logic        av_waitrequest,
    output logic        txd,
    output logic        tx_busy
);

    localparam logic [15:0]      BAUD_LOAD  = 16'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] FIFO_DEPTH = (FIFO_AW+1)'(1) << FIFO_AW;

    tx_state_e        state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             tx_busy_q, tx_busy_d;

    logic             sel_data;
    logic             sel_status;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic [15:0]      status_word;
    logic             bit_tick;
    logic [7:0]       unused_wdata_hi;

    assign unused_wdata_hi = av_writedata[15:8];

    assign sel_data   = (av_address == BASE_ADDR);
    assign sel_status = (av_address == BASE_ADDR + 16'd1);

    // Full is the pre-pop value, so a write colliding with a pop still waits one cycle
    assign av_waitrequest = av_write & sel_data & fifo_full;
    assign fifo_push      = av_write & sel_data & ~fifo_full;

    uart_sync_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (av_writedata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // STATUS word and read mux; a concurrent write takes priority and reads 0
    always_comb begin
        status_word                 = '0;
        status_word[STAT_BUSY_BIT]  = tx_busy_q;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_FREE_LSB +: 8] = 8'(FIFO_DEPTH - fifo_count);
        av_readdata = '0;
        if (av_read && !av_write && sel_status) begin
            av_readdata = status_word;
        end
    end

    assign bit_tick = (baud_q == '0);

    // Shift FSM next state, FIFO pop, bit counter, baud counter, registered line level
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        fifo_pop  = 1'b0;
        txd_d     = 1'b1;
        tx_busy_d = (state_q != ST_IDLE) | ~fifo_empty;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    // rotate so the full byte is back in place for the parity XOR
                    shift_d   = {shift_q[0], shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef AV_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q == ST_IDLE) begin
            baud_d = (state_d != ST_IDLE) ? BAUD_LOAD : '0;
        end else if (bit_tick) begin
            baud_d = (state_d == ST_IDLE) ? '0 : BAUD_LOAD;
        end else begin
            baud_d = baud_q - 16'd1;
        end

        unique case (state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_q[0];
            ST_PARITY: txd_d = ^shift_q;
            default:   txd_d = 1'b1;
        endcase
    end

    // Transmitter state registers; reset forces the line idle immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            txd_q     <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            txd_q     <= txd_d;
            tx_busy_q <= tx_busy_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_av_uart_tx_responder.sv
// Directed bench for av_uart_tx_responder with BAUD_DIV=4, FIFO_AW=2.
// Honours AV_UART_TX_PARITY_EN for the frame length and parity checks.
module tb_av_uart_tx_responder;

    localparam logic [15:0] BASE = 16'h0100;
    localparam int unsigned BD   = 4;
`ifdef AV_UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME_CYC = FRAME_BITS * BD;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] av_address;
    logic [15:0] av_writedata;
    logic        av_write;
    logic        av_read;
    logic [15:0] av_readdata;
    logic        av_waitrequest;
    logic        txd;
    logic        tx_busy;

    int unsigned checks = 0;
    int unsigned passes = 0;
    logic [15:0] seen_v;

    av_uart_tx_responder #(
        .BASE_ADDR (BASE),
        .BAUD_DIV  (BD),
        .FIFO_AW   (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .av_address     (av_address),
        .av_writedata   (av_writedata),
        .av_write       (av_write),
        .av_read        (av_read),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .txd            (txd),
        .tx_busy        (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    // Expected line level for bit slot i of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int unsigned i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (FRAME_BITS == 11 && i == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic bus_idle();
        av_write     = 1'b0;
        av_read      = 1'b0;
        av_address   = '0;
        av_writedata = '0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        int unsigned n = 0;
        av_write     = 1'b1;
        av_address   = a;
        av_writedata = d;
        @(negedge clk);
        while (av_waitrequest && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("write_accept_bound", 16'(n >= 200), 16'd0);
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic read_status(input string tag, input logic [15:0] exp);
        av_read    = 1'b1;
        av_address = BASE + 16'd1;
        #1;
        check(tag, av_readdata, exp);
        av_read    = 1'b0;
        av_address = '0;
    endtask

    // Sends one byte from an idle DUT and checks latency, every cycle of the frame, and tx_busy
    task automatic run_frame(input logic [7:0] b);
        seen_v = '0;
        bus_write(BASE, {8'h00, b});
        @(negedge clk);
        check("latency_edge1_txd", 16'(txd), 16'd1);
        @(negedge clk);
        check("latency_edge2_txd", 16'(txd), 16'd1);
        check("busy_before_start", 16'(tx_busy), 16'd1);
        for (int unsigned i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            check("frame_txd", 16'(txd), 16'(frame_bit(b, i / BD)));
            check("frame_busy", 16'(tx_busy), 16'd1);
            if (i % BD == 1) seen_v[i / BD] = txd;
        end
        @(negedge clk);
        check("after_frame_txd", 16'(txd), 16'd1);
        check("after_frame_busy", 16'(tx_busy), 16'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while (tx_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check(tag, 16'(n < 2000), 16'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  bytes [6];
        int unsigned w;
        int unsigned waitcnt;
        int unsigned sidx;
        int unsigned lows;
        logic        started;

        bytes = '{8'h55, 8'hA3, 8'h0F, 8'hF0, 8'h81, 8'h3C};

        // Reset state
        reset_n = 1'b0;
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_txd", 16'(txd), 16'd1);
        check("reset_busy", 16'(tx_busy), 16'd0);
        check("reset_wait", 16'(av_waitrequest), 16'd0);
        check("reset_readdata", av_readdata, 16'h0000);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        read_status("status_after_reset", 16'h0404);

        // Single 0x41 frame
        run_frame(8'h41);
`ifdef AV_UART_TX_PARITY_EN
        check("frame_0x41_bits", seen_v, 16'h0482);
`else
        check("frame_0x41_bits", seen_v, 16'h0282);
`endif

        // Six back-to-back writes: five fit (one is popped at once), the sixth
        // waits until the end of the first frame; the stream must be gapless
        w       = 0;
        waitcnt = 0;
        sidx    = 0;
        started = 1'b0;
        for (int unsigned cyc = 0; cyc < FRAME_CYC * 6 + 40; cyc++) begin
            if (w < 6) begin
                av_write     = 1'b1;
                av_address   = BASE;
                av_writedata = {8'hEE, bytes[w]};
            end else begin
                bus_idle();
            end
            @(negedge clk);
            if (av_write) begin
                if (av_waitrequest) waitcnt++;
                else w++;
            end
            if (!started && txd == 1'b0) started = 1'b1;
            if (started && sidx < FRAME_CYC * 6) begin
                check("stream_txd", 16'(txd),
                      16'(frame_bit(bytes[sidx / FRAME_CYC], (sidx % FRAME_CYC) / BD)));
                sidx++;
            end
            @(posedge clk);
            #1;
        end
        bus_idle();
        check("burst_all_accepted", 16'(w), 16'd6);
        check("burst_wait_cycles", 16'(waitcnt), 16'(FRAME_CYC - 3));
        check("burst_stream_len", 16'(sidx), 16'(FRAME_CYC * 6));
        check("burst_idle_busy", 16'(tx_busy), 16'd0);

        // STATUS with one byte shifting and one queued
        bus_write(BASE, 16'h0012);
        bus_write(BASE, 16'h0034);
        read_status("status_two_queued", 16'h0301);
        drain("drain_two_bound");

        // Reset during data bit 3 of a 0x00 frame
        bus_write(BASE, 16'h0000);
        repeat (20) @(negedge clk);
        check("bit3_low_before_reset", 16'(txd), 16'd0);
        #1;
        reset_n = 1'b0;
        #1;
        check("txd_async_reset", 16'(txd), 16'd1);
        check("busy_async_reset", 16'(tx_busy), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd == 1'b0) lows++;
        end
        check("no_residual_frame", 16'(lows), 16'd0);
        @(posedge clk);
        #1;
        read_status("status_after_midframe_reset", 16'h0404);

        // Unmapped addresses and read/write collisions
        av_write     = 1'b1;
        av_address   = 16'h0102;
        av_writedata = 16'h0055;
        @(negedge clk);
        check("unmapped_write_wait", 16'(av_waitrequest), 16'd0);
        @(posedge clk);
        #1;
        bus_idle();
        @(posedge clk);
        #1;
        read_status("status_after_unmapped_write", 16'h0404);
        av_read    = 1'b1;
        av_address = 16'h0000;
        #1;
        check("read_unmapped", av_readdata, 16'h0000);
        av_address = BASE;
        #1;
        check("read_data_reg", av_readdata, 16'h0000);
        av_address = BASE + 16'd1;
        av_write   = 1'b1;
        #1;
        check("read_write_collision", av_readdata, 16'h0000);
        check("status_write_wait", 16'(av_waitrequest), 16'd0);
        @(posedge clk);
        #1;
        bus_idle();
        @(posedge clk);
        #1;
        read_status("status_after_status_write", 16'h0404);

        // Full FIFO: only DATA writes are back-pressured
        for (int unsigned i = 0; i < 5; i++) begin
            bus_write(BASE, 16'(8'h30 + i));
        end
        read_status("status_full", 16'h0003);
        av_write   = 1'b1;
        av_address = 16'h0102;
        #1;
        check("unmapped_wait_when_full", 16'(av_waitrequest), 16'd0);
        av_address = BASE;
        #1;
        check("data_wait_when_full", 16'(av_waitrequest), 16'd1);
        bus_idle();
        drain("drain_full_bound");
        read_status("status_drained", 16'h0404);

`ifdef AV_UART_TX_PARITY_EN
        run_frame(8'h07);
        check("parity_0x07_bit", 16'(seen_v[9]), 16'd1);
        check("frame_0x07_bits", seen_v, 16'h060E);
        run_frame(8'h03);
        check("parity_0x03_bit", 16'(seen_v[9]), 16'd0);
        check("frame_0x03_bits", seen_v, 16'h0406);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
